// File: rtl/alu_seq_if.sv
// Request/response bus between the datapath and alu_seq. Requests use valid/ready and so do results.
// The master drives requests and consumes results. The slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [3:0]       OP;
  logic [WIDTH-1:0] ACC_IN;
  logic [WIDTH-1:0] BREG_IN;
  logic [WIDTH-1:0] ALU_OUT;
  logic [3:0]       FLAGS;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport master (
    output IN_VALID, OP, ACC_IN, BREG_IN, OUT_READY,
    input  IN_READY, ALU_OUT, FLAGS, OUT_VALID
  );

  modport slave (
    input  IN_VALID, OP, ACC_IN, BREG_IN, OUT_READY,
    output IN_READY, ALU_OUT, FLAGS, OUT_VALID
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit handshaked ALU with registered N/Z/C/V flags and iterative shifts and multiply.
// Define ALU_MUL_EN to build the shift-add multiplier for opcode 1011. Otherwise 1011 is a reserved opcode.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_DEC = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SAR = 4'hA;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hB;
  localparam logic [SW:0] CNT_MUL = (SW+1)'(WIDTH);
`endif
  localparam logic [SW:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [SW:0]      cnt_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;

  logic             in_ready, accept, is_shift, is_mul, multi;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] b_eff, sc_res, work_d, fin_res;
  logic [WIDTH:0]   sum, dif;
  logic             sc_c, sc_v, shift_out, fin_c, fin_v;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     mul_sum;

  // Low half starts as the multiplier and is consumed LSB-first as the partial product shifts in.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
  assign is_mul  = (bus.OP == OP_MUL);
`else
  assign is_mul  = 1'b0;
`endif

  assign shamt         = bus.BREG_IN[SW-1:0];
  assign is_shift      = (bus.OP == OP_SHL) || (bus.OP == OP_SHR) || (bus.OP == OP_SAR);
  assign multi         = (is_shift && (shamt != '0)) || is_mul;
  assign in_ready      = (state_q == IDLE) || ((state_q == DONE) && bus.OUT_READY);
  assign accept        = bus.IN_VALID && in_ready;
  assign bus.IN_READY  = in_ready;
  assign bus.ALU_OUT   = alu_out_q;
  assign bus.FLAGS     = flags_q;
  assign bus.OUT_VALID = out_valid_q;

  function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  // Single-cycle result. DEC and INC reuse the subtractor and adder with B forced to 1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sc_res = bus.ACC_IN;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    b_eff  = ((bus.OP == OP_DEC) || (bus.OP == OP_INC)) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.BREG_IN;
    sum    = {1'b0, bus.ACC_IN} + {1'b0, b_eff};
    dif    = {1'b0, bus.ACC_IN} - {1'b0, b_eff};
    case (bus.OP)
      OP_ADD, OP_INC: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (bus.ACC_IN[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.ACC_IN[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (bus.ACC_IN[WIDTH-1] != b_eff[WIDTH-1]) && (dif[WIDTH-1] != bus.ACC_IN[WIDTH-1]);
      end
      OP_NOT:  sc_res = ~bus.ACC_IN;
      OP_AND:  sc_res = bus.ACC_IN & bus.BREG_IN;
      OP_OR:   sc_res = bus.ACC_IN | bus.BREG_IN;
      OP_XOR:  sc_res = bus.ACC_IN ^ bus.BREG_IN;
      default: sc_res = bus.ACC_IN;
    endcase
  end

  // One-bit shift step, and the value to publish when the last EXEC cycle completes.
  always_comb begin
    work_d    = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    shift_out = work_q[0];
    case (op_q)
      OP_SHL: begin
        work_d    = {work_q[WIDTH-2:0], 1'b0};
        shift_out = work_q[WIDTH-1];
      end
      OP_SHR:  work_d = {1'b0, work_q[WIDTH-1:1]};
      default: ;
    endcase
    fin_res = work_d;
    fin_c   = shift_out;
    fin_v   = 1'b0;
`ifdef ALU_MUL_EN
    if (op_q == OP_MUL) begin
      fin_res = prod_d[WIDTH-1:0];
      fin_c   = 1'b0;
      fin_v   = |prod_d[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge CLK) begin
    // NOTE: working registers are cleared too, so an aborted operation leaves nothing stale.
    if (RST) begin
      state_q     <= IDLE;
      op_q        <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      alu_out_q   <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      prod_q      <= '0;
`endif
    end else begin
      // NOTE: all state updates are non-blocking, so every branch sees the pre-edge values.
      case (state_q)
        IDLE, DONE: begin
          if ((state_q == DONE) && bus.OUT_READY) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            op_q <= bus.OP;
            if (multi) begin
              state_q     <= EXEC;
              out_valid_q <= 1'b0;
              work_q      <= bus.ACC_IN;
              cnt_q       <= {1'b0, shamt};
`ifdef ALU_MUL_EN
              if (is_mul) begin
                cnt_q   <= CNT_MUL;
                mcand_q <= bus.ACC_IN;
                prod_q  <= {{WIDTH{1'b0}}, bus.BREG_IN};
              end
`endif
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              alu_out_q   <= sc_res;
              flags_q     <= flags_of(sc_res, sc_c, sc_v);
            end
          end
        end
        EXEC: begin
          cnt_q  <= cnt_q - CNT_ONE;
          work_q <= work_d;
`ifdef ALU_MUL_EN
          prod_q <= prod_d;
`endif
          if (cnt_q == CNT_ONE) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            alu_out_q   <= fin_res;
            flags_q     <= flags_of(fin_res, fin_c, fin_v);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=8. Expected values are hand-computed.
// Expectations for the MUL tests depend on ALU_MUL_EN.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 8;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0] fl;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  alu_seq_if #(.WIDTH(W)) bus_if ();
  alu_seq #(.WIDTH(W)) dut (.CLK(clk), .RST(rst), .bus(bus_if));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one request from IDLE and measure cycles from the accept edge until OUT_VALID.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit rdy_seen);
    @(negedge clk);
    bus_if.IN_VALID  = 1'b1;
    bus_if.OP        = op;
    bus_if.ACC_IN    = a;
    bus_if.BREG_IN   = b;
    bus_if.OUT_READY = 1'b0;
    @(posedge clk); #1;
    bus_if.IN_VALID = 1'b0;
    bus_if.OP       = 4'h6;
    bus_if.ACC_IN   = '1;
    bus_if.BREG_IN  = '1;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus_if.OUT_VALID && lat < 40) begin
      if (bus_if.IN_READY) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus_if.OUT_READY = 1'b1;
    @(posedge clk); #1;
    bus_if.OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.IN_VALID = 1'b0; bus_if.OP = '0; bus_if.ACC_IN = '0; bus_if.BREG_IN = '0;
    bus_if.OUT_READY = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus_if.OUT_VALID !== 1'b0) $display("FAIL reset OUT_VALID: got %b expected 0", bus_if.OUT_VALID); else n_pass++;
    n_total++; if (bus_if.ALU_OUT !== 8'h00) $display("FAIL reset ALU_OUT: got %h expected 00", bus_if.ALU_OUT); else n_pass++;
    n_total++; if (bus_if.FLAGS !== 4'h0) $display("FAIL reset FLAGS: got %b expected 0000", bus_if.FLAGS); else n_pass++;
    n_total++; if (bus_if.IN_READY !== 1'b1) $display("FAIL reset IN_READY: got %b expected 1", bus_if.IN_READY); else n_pass++;
  endtask

  task automatic test_arith_logic();
    vec_t v[8];
    int   lat;
    bit   rdy;
    v[0] = '{"add_7f_01", 4'h0, 8'h7F, 8'h01, 8'h80, 4'b1001, 1};
    v[1] = '{"sub_00_01", 4'h1, 8'h00, 8'h01, 8'hFF, 4'b1010, 1};
    v[2] = '{"dec_00",    4'h2, 8'h00, 8'h55, 8'hFF, 4'b1010, 1};
    v[3] = '{"inc_ff",    4'h3, 8'hFF, 8'h55, 8'h00, 4'b0110, 1};
    v[4] = '{"not_0f",    4'h4, 8'h0F, 8'h00, 8'hF0, 4'b1000, 1};
    v[5] = '{"and_f0_3c", 4'h5, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1};
    v[6] = '{"or_05_a0",  4'h6, 8'h05, 8'hA0, 8'hA5, 4'b1000, 1};
    v[7] = '{"xor_aa_aa", 4'h7, 8'hAA, 8'hAA, 8'h00, 4'b0100, 1};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, rdy);
      n_total++; if (bus_if.ALU_OUT !== v[i].res) $display("FAIL %s result: got %h expected %h", v[i].name, bus_if.ALU_OUT, v[i].res); else n_pass++;
      n_total++; if (bus_if.FLAGS !== v[i].fl) $display("FAIL %s flags: got %b expected %b", v[i].name, bus_if.FLAGS, v[i].fl); else n_pass++;
      n_total++; if (lat !== v[i].lat) $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); else n_pass++;
      consume();
    end
  endtask

  task automatic test_shift();
    vec_t v[5];
    int   lat;
    bit   rdy;
    v[0] = '{"sar_90_s3",  4'hA, 8'h90, 8'h03, 8'hF2, 4'b1000, 4};
    v[1] = '{"shl_81_s1",  4'h8, 8'h81, 8'h01, 8'h02, 4'b0010, 2};
    v[2] = '{"shr_5a_s0",  4'h9, 8'h5A, 8'h08, 8'h5A, 4'b0000, 1};
    v[3] = '{"shr_01_s1",  4'h9, 8'h01, 8'h01, 8'h00, 4'b0110, 2};
    v[4] = '{"shl_c3_s7",  4'h8, 8'hC3, 8'hF7, 8'h80, 4'b1010, 8};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, rdy);
      n_total++; if (bus_if.ALU_OUT !== v[i].res) $display("FAIL %s result: got %h expected %h", v[i].name, bus_if.ALU_OUT, v[i].res); else n_pass++;
      n_total++; if (bus_if.FLAGS !== v[i].fl) $display("FAIL %s flags: got %b expected %b", v[i].name, bus_if.FLAGS, v[i].fl); else n_pass++;
      n_total++; if (lat !== v[i].lat) $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); else n_pass++;
      n_total++; if (rdy !== 1'b0) $display("FAIL %s ready_in_exec: got %b expected 0", v[i].name, rdy); else n_pass++;
      consume();
    end
  endtask

  task automatic test_mul_reserved();
    int lat;
    bit rdy;
`ifdef ALU_MUL_EN
    logic [3:0] exp_fl  = 4'b0001;
    int         exp_lat = 9;
`else
    logic [3:0] exp_fl  = 4'b0000;
    int         exp_lat = 1;
`endif
    run_op(4'hB, 8'h10, 8'h11, lat, rdy);
    n_total++; if (bus_if.ALU_OUT !== 8'h10) $display("FAIL mul result: got %h expected 10", bus_if.ALU_OUT); else n_pass++;
    n_total++; if (bus_if.FLAGS !== exp_fl) $display("FAIL mul flags: got %b expected %b", bus_if.FLAGS, exp_fl); else n_pass++;
    n_total++; if (lat !== exp_lat) $display("FAIL mul latency: got %0d expected %0d", lat, exp_lat); else n_pass++;
    n_total++; if (rdy !== 1'b0) $display("FAIL mul ready_in_exec: got %b expected 0", rdy); else n_pass++;
    consume();
    run_op(4'hD, 8'h85, 8'h7B, lat, rdy);
    n_total++; if (bus_if.ALU_OUT !== 8'h85) $display("FAIL reserved result: got %h expected 85", bus_if.ALU_OUT); else n_pass++;
    n_total++; if (bus_if.FLAGS !== 4'b1000) $display("FAIL reserved flags: got %b expected 1000", bus_if.FLAGS); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL reserved latency: got %0d expected 1", lat); else n_pass++;
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit rdy;
    run_op(4'h0, 8'h12, 8'h34, lat, rdy);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if (bus_if.ALU_OUT !== 8'h46 || bus_if.FLAGS !== 4'b0000 || bus_if.IN_READY !== 1'b0 || bus_if.OUT_VALID !== 1'b1)
        $display("FAIL hold cycle %0d: got out=%h fl=%b rdy=%b vld=%b expected out=46 fl=0000 rdy=0 vld=1",
                 c, bus_if.ALU_OUT, bus_if.FLAGS, bus_if.IN_READY, bus_if.OUT_VALID);
      else n_pass++;
    end
    bus_if.OUT_READY = 1'b1;
    bus_if.IN_VALID  = 1'b1;
    bus_if.OP        = 4'h7;
    bus_if.ACC_IN    = 8'h0F;
    bus_if.BREG_IN   = 8'hFF;
    #1;
    n_total++; if (bus_if.IN_READY !== 1'b1) $display("FAIL b2b IN_READY: got %b expected 1", bus_if.IN_READY); else n_pass++;
    @(posedge clk); #1;
    bus_if.IN_VALID  = 1'b0;
    bus_if.OUT_READY = 1'b0;
    n_total++; if (bus_if.OUT_VALID !== 1'b1) $display("FAIL b2b OUT_VALID: got %b expected 1", bus_if.OUT_VALID); else n_pass++;
    n_total++; if (bus_if.ALU_OUT !== 8'hF0) $display("FAIL b2b result: got %h expected f0", bus_if.ALU_OUT); else n_pass++;
    n_total++; if (bus_if.FLAGS !== 4'b1000) $display("FAIL b2b flags: got %b expected 1000", bus_if.FLAGS); else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid_op();
    bit stale = 1'b0;
    @(negedge clk);
    bus_if.IN_VALID = 1'b1;
`ifdef ALU_MUL_EN
    bus_if.OP = 4'hB; bus_if.ACC_IN = 8'h10; bus_if.BREG_IN = 8'h11;
`else
    bus_if.OP = 4'h8; bus_if.ACC_IN = 8'h01; bus_if.BREG_IN = 8'h07;
`endif
    @(posedge clk); #1;
    bus_if.IN_VALID = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (bus_if.OUT_VALID !== 1'b0) $display("FAIL midrst OUT_VALID: got %b expected 0", bus_if.OUT_VALID); else n_pass++;
    n_total++; if (bus_if.ALU_OUT !== 8'h00) $display("FAIL midrst ALU_OUT: got %h expected 00", bus_if.ALU_OUT); else n_pass++;
    n_total++; if (bus_if.FLAGS !== 4'h0) $display("FAIL midrst FLAGS: got %b expected 0000", bus_if.FLAGS); else n_pass++;
    n_total++; if (bus_if.IN_READY !== 1'b1) $display("FAIL midrst IN_READY: got %b expected 1", bus_if.IN_READY); else n_pass++;
    repeat (15) begin
      @(negedge clk);
      if (bus_if.OUT_VALID) stale = 1'b1;
    end
    n_total++; if (stale !== 1'b0) $display("FAIL midrst stale_output: got %b expected 0", stale); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith_logic();
    test_shift();
    test_mul_reserved();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
